// File: rtl/mprj_io_cfg_sequencer.sv
// mprj_io_cfg_sequencer: walks pads NUM_PADS-1..0, fetches each pad's
// config word and shifts it MSB-first into the user I/O chain, then
// strobes serial_load.
// Ports: clock/resetb (async active-low), start/abort requests,
// cfg_addr/cfg_data word fetch, serial_clock/serial_data/serial_load
// chain drive, busy (not idle), done (one-cycle completion pulse).
module mprj_io_cfg_sequencer #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int ADDR_W   = 6
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                start,
  input  logic                abort,
  output logic [ADDR_W-1:0]   cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load,
  output logic                busy,
  output logic                done
);

  localparam int CW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    BIT_LO,
    BIT_HI,
    LOAD
  } state_t;

  state_t              state, state_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [CFG_BITS-1:0] sr, sr_d, sr_sh;
  logic [ADDR_W-1:0]   addr_d;
  logic                sclk_d, sdat_d, sload_d;
  logic                busy_d, done_d;

  assign sr_sh = sr << 1;

  // Outputs are computed for the state being entered and registered
  // with it, so each output reflects the current state with no glitches.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sr_d    = sr;
    addr_d  = cfg_addr;
    sclk_d  = 1'b0;
    sdat_d  = 1'b0;
    sload_d = 1'b0;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d = FETCH;
          addr_d  = ADDR_W'(NUM_PADS - 1);
          cnt_d   = '0;
        end
      end
      FETCH: begin
        sr_d    = cfg_data;
        sdat_d  = cfg_data[CFG_BITS-1];
        state_d = BIT_LO;
      end
      BIT_LO: begin
        sclk_d  = 1'b1;
        sdat_d  = sr[CFG_BITS-1];
        state_d = BIT_HI;
      end
      BIT_HI: begin
        sr_d = sr_sh;
        if (cnt == CW'(CFG_BITS - 1)) begin
          cnt_d = '0;
          if (cfg_addr == '0) begin
            state_d = LOAD;
            sload_d = 1'b1;
          end else begin
            state_d = FETCH;
            addr_d  = cfg_addr - 1'b1;
          end
        end else begin
          cnt_d   = cnt + 1'b1;
          sdat_d  = sr_sh[CFG_BITS-1];
          state_d = BIT_LO;
        end
      end
      LOAD: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort cancels cleanly: chain lines low, no load, no done
    if (abort && state != IDLE) begin
      state_d = IDLE;
      cnt_d   = cnt;
      sr_d    = sr;
      addr_d  = cfg_addr;
      sclk_d  = 1'b0;
      sdat_d  = 1'b0;
      sload_d = 1'b0;
      done_d  = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state        <= IDLE;
      cnt          <= '0;
      sr           <= '0;
      cfg_addr     <= '0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      sr           <= sr_d;
      cfg_addr     <= addr_d;
      serial_clock <= sclk_d;
      serial_data  <= sdat_d;
      serial_load  <= sload_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_mprj_io_cfg_sequencer.sv
// Directed bench for mprj_io_cfg_sequencer: a 2-pad/3-bit instance for
// waveform checks and a default instance for the full-chain counts.
module tb_mprj_io_cfg_sequencer;

  logic clk;
  logic resetb;

  logic       s_start, s_abort;
  logic [0:0] s_addr;
  logic [2:0] s_data;
  logic       s_sclk, s_sdat, s_sload, s_busy, s_done;

  logic        b_start, b_abort;
  logic [5:0]  b_addr;
  logic [12:0] b_data;
  logic        b_sclk, b_sdat, b_sload, b_busy, b_done;

  int vecs = 0;
  int errs = 0;

  logic cap_clk   [0:40];
  logic cap_dat   [0:40];
  logic cap_load  [0:40];
  logic cap_done  [0:40];
  logic cap_busy  [0:40];
  logic cap_addr  [0:40];

  mprj_io_cfg_sequencer #(
    .NUM_PADS(2), .CFG_BITS(3), .ADDR_W(1)
  ) u_small (
    .clock(clk), .resetb(resetb),
    .start(s_start), .abort(s_abort),
    .cfg_addr(s_addr), .cfg_data(s_data),
    .serial_clock(s_sclk), .serial_data(s_sdat),
    .serial_load(s_sload), .busy(s_busy), .done(s_done)
  );

  mprj_io_cfg_sequencer u_big (
    .clock(clk), .resetb(resetb),
    .start(b_start), .abort(b_abort),
    .cfg_addr(b_addr), .cfg_data(b_data),
    .serial_clock(b_sclk), .serial_data(b_sdat),
    .serial_load(b_sload), .busy(b_busy), .done(b_done)
  );

  assign s_data = (s_addr == 1'b1) ? 3'b101 : 3'b011;
  assign b_data = {b_addr, 7'h2b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; cycle 1 is the first FETCH cycle.
  task automatic capture(input int ncyc, input int st2, input int ab);
    cap_clk[0] = s_sclk;
    for (int c = 1; c <= ncyc; c++) begin
      s_start = (c == 1) || (c == st2);
      s_abort = (c == ab + 1);
      @(posedge clk);
      @(negedge clk);
      cap_clk[c]  = s_sclk;
      cap_dat[c]  = s_sdat;
      cap_load[c] = s_sload;
      cap_done[c] = s_done;
      cap_busy[c] = s_busy;
      cap_addr[c] = s_addr[0];
    end
    s_start = 1'b0;
    s_abort = 1'b0;
  endtask

  task automatic extract(input int ncyc, output int n,
                         output logic [7:0] bits);
    n = 0;
    bits = '0;
    for (int c = 1; c <= ncyc; c++)
      if (cap_clk[c] && !cap_clk[c-1]) begin
        bits = {bits[6:0], cap_dat[c]};
        n++;
      end
  endtask

  task automatic tally(input int ncyc, output int nl, output int nd,
                       output int nb, output int nov);
    nl = 0; nd = 0; nb = 0; nov = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (cap_load[c]) nl++;
      if (cap_done[c]) nd++;
      if (cap_busy[c]) nb++;
      if (cap_load[c] && cap_clk[c]) nov++;
    end
  endtask

  task automatic test_reset;
    #1;
    vecs++;
    if ({s_sclk, s_sdat, s_sload, s_busy, s_done, s_addr} !== 6'b0) begin
      errs++;
      $display("FAIL reset_small got %b want 000000",
               {s_sclk, s_sdat, s_sload, s_busy, s_done, s_addr});
    end
    vecs++;
    if ({b_sclk, b_sdat, b_sload, b_busy, b_done, b_addr} !== 11'b0) begin
      errs++;
      $display("FAIL reset_big got %b want 0",
               {b_sclk, b_sdat, b_sload, b_busy, b_done, b_addr});
    end
  endtask

  task automatic test_basic;
    int n, nl, nd, nb, nov;
    logic [7:0] bits;
    capture(20, 0, -10);
    extract(20, n, bits);
    tally(20, nl, nd, nb, nov);
    vecs++;
    if (n !== 6 || bits[5:0] !== 6'b101011) begin
      errs++;
      $display("FAIL basic_bits got n=%0d %b want n=6 101011",
               n, bits[5:0]);
    end
    vecs++;
    if (cap_load[15] !== 1'b1 || nl !== 1) begin
      errs++;
      $display("FAIL basic_load got c15=%b n=%0d want 1 1",
               cap_load[15], nl);
    end
    vecs++;
    if (cap_done[16] !== 1'b1 || nd !== 1) begin
      errs++;
      $display("FAIL basic_done got c16=%b n=%0d want 1 1",
               cap_done[16], nd);
    end
    vecs++;
    if (nb !== 15 || cap_busy[16] !== 1'b0) begin
      errs++;
      $display("FAIL basic_busy got %0d c16=%b want 15 0",
               nb, cap_busy[16]);
    end
    vecs++;
    if (cap_addr[1] !== 1'b1 || cap_addr[8] !== 1'b0) begin
      errs++;
      $display("FAIL basic_addr got %b %b want 1 0",
               cap_addr[1], cap_addr[8]);
    end
    vecs++;
    if (nov !== 0) begin
      errs++;
      $display("FAIL basic_overlap got %0d want 0", nov);
    end
  endtask

  task automatic test_back_to_back;
    int n, nl, nd, nb, nov;
    logic [7:0] bits;
    capture(30, 13, -10);
    extract(30, n, bits);
    tally(30, nl, nd, nb, nov);
    vecs++;
    if (n !== 6 || bits[5:0] !== 6'b101011) begin
      errs++;
      $display("FAIL restart_bits got n=%0d %b want n=6 101011",
               n, bits[5:0]);
    end
    vecs++;
    if (nd !== 1 || nl !== 1 || cap_load[15] !== 1'b1) begin
      errs++;
      $display("FAIL restart_single got done=%0d load=%0d want 1 1",
               nd, nl);
    end
    vecs++;
    if (nb !== 15 || cap_busy[17] !== 1'b0) begin
      errs++;
      $display("FAIL restart_busy got %0d c17=%b want 15 0",
               nb, cap_busy[17]);
    end
  endtask

  task automatic test_abort;
    int n, nl, nd, nb, nov;
    logic [7:0] bits;
    capture(20, 0, 7);
    tally(20, nl, nd, nb, nov);
    vecs++;
    if (cap_busy[7] !== 1'b1 || cap_busy[8] !== 1'b0 ||
        cap_clk[8] !== 1'b0) begin
      errs++;
      $display("FAIL abort_idle got busy7=%b busy8=%b sclk8=%b want 1 0 0",
               cap_busy[7], cap_busy[8], cap_clk[8]);
    end
    vecs++;
    if (nl !== 0 || nd !== 0) begin
      errs++;
      $display("FAIL abort_quiet got load=%0d done=%0d want 0 0", nl, nd);
    end
    vecs++;
    if (cap_addr[10] !== 1'b1) begin
      errs++;
      $display("FAIL abort_addr_hold got %b want 1", cap_addr[10]);
    end
    capture(20, 0, -10);
    extract(20, n, bits);
    vecs++;
    if (n !== 6 || bits[5:0] !== 6'b101011 || cap_done[16] !== 1'b1) begin
      errs++;
      $display("FAIL abort_rerun got n=%0d %b done=%b want 6 101011 1",
               n, bits[5:0], cap_done[16]);
    end
  endtask

  task automatic test_start_abort_idle;
    int act;
    act = 0;
    s_start = 1'b1;
    s_abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    s_abort = 1'b0;
    vecs++;
    if (s_busy !== 1'b0) begin
      errs++;
      $display("FAIL both_busy got %b want 0", s_busy);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (s_busy || s_sclk) act++;
    end
    vecs++;
    if (act !== 0) begin
      errs++;
      $display("FAIL both_activity got %0d want 0", act);
    end
  endtask

  task automatic test_defaults;
    int nb, nr, nl, nd, nov, d1028;
    logic prev;
    logic [5:0] a1;
    nb = 0; nr = 0; nl = 0; nd = 0; nov = 0; d1028 = 0;
    prev = b_sclk;
    a1 = '0;
    b_start = 1'b1;
    for (int c = 1; c <= 1100; c++) begin
      @(posedge clk);
      @(negedge clk);
      b_start = 1'b0;
      if (c == 1) a1 = b_addr;
      if (b_busy) nb++;
      if (b_sclk && !prev) nr++;
      if (b_sload) nl++;
      if (b_done) nd++;
      if (b_sload && b_sclk) nov++;
      if (c == 1028 && b_done) d1028 = 1;
      prev = b_sclk;
    end
    vecs++;
    if (nb !== 1027) begin
      errs++;
      $display("FAIL dflt_busy got %0d want 1027", nb);
    end
    vecs++;
    if (nr !== 494) begin
      errs++;
      $display("FAIL dflt_sclk_rises got %0d want 494", nr);
    end
    vecs++;
    if (nl !== 1 || nd !== 1 || d1028 !== 1) begin
      errs++;
      $display("FAIL dflt_load_done got %0d %0d at1028=%0d want 1 1 1",
               nl, nd, d1028);
    end
    vecs++;
    if (a1 !== 6'd37 || nov !== 0) begin
      errs++;
      $display("FAIL dflt_addr_overlap got %0d %0d want 37 0", a1, nov);
    end
  endtask

  task automatic test_async_reset;
    int nl;
    nl = 0;
    capture(3, 0, -10);
    vecs++;
    if (s_sclk !== 1'b1) begin
      errs++;
      $display("FAIL arst_pre got sclk=%b want 1", s_sclk);
    end
    #2;
    resetb = 1'b0;
    #1;
    vecs++;
    if ({s_sclk, s_busy, s_sload, s_done, s_addr} !== 5'b0) begin
      errs++;
      $display("FAIL arst_now got %b want 00000",
               {s_sclk, s_busy, s_sload, s_done, s_addr});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (s_sload || s_done) nl++;
    end
    vecs++;
    if (nl !== 0) begin
      errs++;
      $display("FAIL arst_noload got %0d want 0", nl);
    end
    resetb = 1'b1;
    s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    vecs++;
    if (s_busy !== 1'b1 || s_addr !== 1'b1) begin
      errs++;
      $display("FAIL arst_first_start got busy=%b addr=%b want 1 1",
               s_busy, s_addr);
    end
    repeat (20) @(negedge clk);
    vecs++;
    if (s_busy !== 1'b0) begin
      errs++;
      $display("FAIL arst_finish got busy=%b want 0", s_busy);
    end
  endtask

  initial begin
    resetb  = 1'b0;
    s_start = 1'b0;
    s_abort = 1'b0;
    b_start = 1'b0;
    b_abort = 1'b0;
    test_reset;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    test_basic;
    test_back_to_back;
    test_abort;
    test_start_abort_idle;
    test_defaults;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mprj_io_cfg_sequencer.md
MPRJ_IO_CFG_SEQUENCER -- requirements
Module: mprj_io_cfg_sequencer

Interface
REQ-001 SHALL have parameter NUM_PADS, default 38, number of user pads in the configuration chain.
REQ-002 SHALL have parameter CFG_BITS, default 13, configuration bits per pad.
REQ-003 SHALL have parameter ADDR_W, default 6, width of cfg_addr (2^ADDR_W >= NUM_PADS).
REQ-004 SHALL have port clock  input  1  the only clock; all state changes on its rising edge.
REQ-005 SHALL have port resetb  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to load the whole chain.
REQ-007 SHALL have port abort  input  1  synchronous cancel of a load in progress.
REQ-008 SHALL have port cfg_addr  output  ADDR_W  index of the pad whose word is being fetched.
REQ-009 SHALL have port cfg_data  input  CFG_BITS  configuration word for cfg_addr, valid in the same cycle.
REQ-010 SHALL have port serial_clock  output  1  chain shift clock.
REQ-011 SHALL have port serial_data  output  1  chain data, MSB of each word first.
REQ-012 SHALL have port serial_load  output  1  one-cycle strobe that transfers chain contents to pad controls.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on successful completion.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 States SHALL be IDLE, FETCH, BIT_LO, BIT_HI, LOAD.
REQ-017 IDLE with start=1 and abort=0 SHALL go to FETCH with cfg_addr=NUM_PADS-1 and bit counter=0.
REQ-018 FETCH SHALL last one cycle, capture cfg_data into the shift register at its end, and go to BIT_LO.
REQ-019 BIT_LO SHALL drive serial_clock=0 and serial_data=shift-register MSB, then go to BIT_HI.
REQ-020 BIT_HI SHALL drive serial_clock=1 with serial_data held, then shift the register left by one and increment the bit counter.
REQ-021 In BIT_HI with bit counter<CFG_BITS-1, next state SHALL be BIT_LO.
REQ-022 In BIT_HI on the last bit, next state SHALL be FETCH with cfg_addr decremented, or LOAD if cfg_addr=0.
REQ-023 LOAD SHALL drive serial_load=1 and serial_clock=0 for exactly one cycle, then go to IDLE.
REQ-024 done SHALL pulse for exactly the first IDLE cycle following LOAD.
REQ-025 Pads SHALL be shifted from NUM_PADS-1 down to 0, so pad 0's word is nearest the chain input.
REQ-026 From the first FETCH cycle through the LOAD cycle, a load SHALL take NUM_PADS*(1+2*CFG_BITS)+1 cycles: 1027 at default parameters.
REQ-027 start while busy=1 SHALL be ignored and not queued.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE next cycle, with serial_clock=0, serial_load=0 and no done pulse.
REQ-029 start and abort both high in IDLE SHALL leave the block in IDLE (abort wins).
REQ-030 serial_load SHALL never be high in the same cycle as serial_clock.
REQ-031 In IDLE, serial_clock, serial_data and serial_load SHALL be 0, and cfg_addr SHALL hold its last value.

Reset
REQ-032 resetb=0 SHALL immediately force state IDLE.
REQ-033 resetb=0 SHALL immediately force cfg_addr=0, bit counter=0 and shift register=0.
REQ-034 resetb=0 SHALL immediately force serial_clock=0, serial_data=0, serial_load=0, busy=0 and done=0, regardless of clock.
REQ-035 Reset asserted mid-load SHALL produce no serial_load and no done.
REQ-036 After resetb rises, the block SHALL accept start on the first rising edge.

Verification
REQ-037 NUM_PADS=2, CFG_BITS=3; cfg_data=3'b101 for pad 1 and 3'b011 for pad 0; start pulse -> serial_data sampled at each serial_clock rise is 1,0,1,0,1,1; serial_load high on cycle 15 after FETCH entry; done high on cycle 16.
REQ-038 Defaults, one start -> busy high 1027 cycles; exactly 494 serial_clock rising edges; exactly one serial_load; exactly one done.
REQ-039 start re-pulsed during the 5th BIT_HI -> waveform identical to REQ-037; single done.
REQ-040 abort at cycle 7 of the REQ-037 load -> IDLE next cycle; serial_load never asserted; done stays 0; a following start completes normally.
REQ-041 resetb low asynchronously mid-BIT_HI -> serial_clock=0 and busy=0 before the next clock edge; no serial_load.
REQ-042 start=1 and abort=1 in the same IDLE cycle -> busy stays 0; no serial_clock activity.
